// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes and the register-file write port of regfile_write_arbiter.
// The arbiter connects through the slave modport; requesters/observers use master.
interface regfile_write_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [63:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [63:0] req1_data;
  logic        req1_ready;
  logic [4:0]  rd;
  logic [63:0] writeData;
  logic        RegWrite;
  logic        busy;
  logic        last_grant;

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    input  rd, writeData, RegWrite, busy, last_grant
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    output rd, writeData, RegWrite, busy, last_grant
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU and load unit.
// Define REGFILE_CLEAR_EN to add a post-reset sweep that zeroes x1..x31.
module regfile_write_arbiter (
  input logic              clk,
  input logic              reset,
  regfile_write_arbiter_if.slave wif
);

  logic        ptr_p1;
  logic        lg_p1;
  logic        we_p1;
  logic [4:0]  rd_p1;
  logic [63:0] data_p1;

  logic        arb_en;
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic        winner;
  logic [4:0]  win_rd;
  logic [63:0] win_data;

`ifdef REGFILE_CLEAR_EN
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0] state;
  logic [4:0] clr_cnt;

  assign arb_en   = (state == ST_ARB);
  assign wif.busy = (state == ST_CLEAR);
`else
  assign arb_en   = 1'b1;
  assign wif.busy = 1'b0;
`endif

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    grant0   = arb_en && wif.req0_valid && (!wif.req1_valid || !ptr_p1);
    grant1   = arb_en && wif.req1_valid && (!wif.req0_valid ||  ptr_p1);
    xfer     = grant0 || grant1;
    winner   = grant1;
    win_rd   = grant1 ? wif.req1_rd   : wif.req0_rd;
    win_data = grant1 ? wif.req1_data : wif.req0_data;
  end

  assign wif.req0_ready = grant0;
  assign wif.req1_ready = grant1;

  // Stage p1: registered write port and arbitration state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_p1  <= 1'b0;
      lg_p1   <= 1'b0;
      we_p1   <= 1'b0;
      rd_p1   <= 5'd0;
      data_p1 <= 64'd0;
`ifdef REGFILE_CLEAR_EN
      state   <= ST_CLEAR;
      clr_cnt <= 5'd1;
`endif
    end
`ifdef REGFILE_CLEAR_EN
    else if (state == ST_CLEAR) begin
      we_p1   <= 1'b1;
      rd_p1   <= clr_cnt;
      data_p1 <= 64'd0;
      clr_cnt <= clr_cnt + 5'd1;
      if (clr_cnt == 5'd31) state <= ST_ARB;
    end
`endif
    else if (xfer) begin
      ptr_p1 <= ~winner;
      lg_p1  <= winner;
      // x0 is hard-wired zero: accept the transfer but suppress the write.
      if (win_rd != 5'd0) begin
        we_p1   <= 1'b1;
        rd_p1   <= win_rd;
        data_p1 <= win_data;
      end else begin
        we_p1   <= 1'b0;
      end
    end else begin
      we_p1 <= 1'b0;
    end
  end

  assign wif.RegWrite   = we_p1;
  assign wif.rd         = rd_p1;
  assign wif.writeData  = data_p1;
  assign wif.last_grant = lg_p1;

endmodule
